// File: rtl/mem_arbiter.sv
// Arbitrates a shared single-port memory between an instruction-fetch and a data
// port; data accesses win, each access is bounded by a MAX_WAIT-cycle timeout.
module mem_arbiter #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        hold_i,

    input  logic        if_ce_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_stallreq_o,

    input  logic        dm_ce_i,
    input  logic        dm_we_i,
    input  logic [31:0] dm_addr_i,
    input  logic [3:0]  dm_sel_i,
    input  logic [31:0] dm_wdata_i,
    output logic [31:0] dm_rdata_o,
    output logic        dm_stallreq_o,

    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_ACC = 2'd1,
        DM_ACC = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state;
    state_t      state_next;
    logic        if_done;
    logic        dm_done;
    logic [7:0]  wait_cnt;

    logic        if_pending;
    logic        dm_pending;
    logic        advance;
    logic        in_access;
    logic        timeout;
    logic        finish;
    logic [31:0] acc_rdata;

    assign if_pending    = if_ce_i & ~if_done;
    assign dm_pending    = dm_ce_i & ~dm_done;
    assign if_stallreq_o = if_pending;
    assign dm_stallreq_o = dm_pending;

    // The pipeline moves on only when nothing else holds it and both ports are served.
    assign advance   = ~hold_i & ~if_pending & ~dm_pending;
    assign in_access = (state != IDLE);
    assign timeout   = in_access & ~bus_ack_i & (wait_cnt == WAIT_LAST);
    assign finish    = in_access & (bus_ack_i | timeout);
    assign acc_rdata = bus_ack_i ? bus_rdata_i : 32'h0;

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (dm_pending) begin
                    state_next = DM_ACC;
                end else if (if_pending) begin
                    state_next = IF_ACC;
                end
            end
            IF_ACC, DM_ACC: begin
                if (finish) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Bus signals are captured once on entry and held until the access finishes.
    always_ff @(posedge clk) begin
        if (clr) begin
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= 32'h0;
            bus_sel_o   <= 4'h0;
            bus_wdata_o <= 32'h0;
        end else if (state == IDLE) begin
            if (dm_pending) begin
                bus_req_o   <= 1'b1;
                bus_we_o    <= dm_we_i;
                bus_addr_o  <= dm_addr_i;
                bus_sel_o   <= dm_sel_i;
                bus_wdata_o <= dm_wdata_i;
            end else if (if_pending) begin
                bus_req_o   <= 1'b1;
                bus_we_o    <= 1'b0;
                bus_addr_o  <= if_addr_i;
                bus_sel_o   <= 4'hF;
                bus_wdata_o <= 32'h0;
            end
        end else if (finish) begin
            bus_req_o <= 1'b0;
            bus_we_o  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wait_cnt <= 8'd0;
        end else if (!in_access || finish) begin
            wait_cnt <= 8'd0;
        end else begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // A pipeline advance clears the done flags even if an orphaned access finishes on the same edge.
    always_ff @(posedge clk) begin
        if (clr) begin
            if_data_o  <= 32'h0;
            dm_rdata_o <= 32'h0;
            if_done    <= 1'b0;
            dm_done    <= 1'b0;
            bus_err_o  <= 1'b0;
        end else begin
            if (finish && (state == DM_ACC) && !bus_we_o) begin
                dm_rdata_o <= acc_rdata;
            end
            if (finish && (state == IF_ACC)) begin
                if_data_o <= acc_rdata;
            end
            if (timeout) begin
                bus_err_o <= 1'b1;
            end

            if (advance) begin
                dm_done <= 1'b0;
            end else if (finish && (state == DM_ACC)) begin
                dm_done <= 1'b1;
            end

            if (advance) begin
                if_done <= 1'b0;
            end else if (finish && (state == IF_ACC)) begin
                if_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: tasks push expected bus accesses and read data,
// a negedge monitor pops them as the DUT starts accesses and drops its stall requests.
module tb_mem_arbiter;

    logic        clk;
    logic        clr;
    logic        hold_i;
    logic        if_ce_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_stallreq_o;
    logic        dm_ce_i;
    logic        dm_we_i;
    logic [31:0] dm_addr_i;
    logic [3:0]  dm_sel_i;
    logic [31:0] dm_wdata_i;
    logic [31:0] dm_rdata_o;
    logic        dm_stallreq_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic        bus_err_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        bit          chk_wdata;
    } bus_exp_t;

    typedef struct {
        bit          chk;
        logic [31:0] data;
    } data_exp_t;

    bus_exp_t  bus_q[$];
    data_exp_t dm_q[$];
    data_exp_t if_q[$];
    bus_exp_t  be;
    data_exp_t de;
    logic      prev_req = 1'b0;
    logic      prev_dm  = 1'b0;
    logic      prev_if  = 1'b0;

    mem_arbiter dut (
        .clk           (clk),
        .clr           (clr),
        .hold_i        (hold_i),
        .if_ce_i       (if_ce_i),
        .if_addr_i     (if_addr_i),
        .if_data_o     (if_data_o),
        .if_stallreq_o (if_stallreq_o),
        .dm_ce_i       (dm_ce_i),
        .dm_we_i       (dm_we_i),
        .dm_addr_i     (dm_addr_i),
        .dm_sel_i      (dm_sel_i),
        .dm_wdata_i    (dm_wdata_i),
        .dm_rdata_o    (dm_rdata_o),
        .dm_stallreq_o (dm_stallreq_o),
        .bus_req_o     (bus_req_o),
        .bus_we_o      (bus_we_o),
        .bus_addr_o    (bus_addr_o),
        .bus_sel_o     (bus_sel_o),
        .bus_wdata_o   (bus_wdata_o),
        .bus_rdata_i   (bus_rdata_i),
        .bus_ack_i     (bus_ack_i),
        .bus_err_o     (bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: compare each new bus access and each completed read against the queues.
    always @(negedge clk) begin
        if (bus_req_o === 1'b1 && prev_req !== 1'b1) begin
            checks++;
            if (bus_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL bus_unexpected: got access addr %h we %b, expected none", bus_addr_o, bus_we_o);
            end else begin
                be = bus_q.pop_front();
                if (bus_we_o !== be.we || bus_addr_o !== be.addr || bus_sel_o !== be.sel ||
                    (be.chk_wdata && bus_wdata_o !== be.wdata)) begin
                    errors++;
                    $display("[TB] FAIL bus_access: got we %b addr %h sel %h wdata %h, expected we %b addr %h sel %h wdata %h",
                             bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o, be.we, be.addr, be.sel, be.wdata);
                end
            end
        end
        if (dm_stallreq_o === 1'b0 && prev_dm === 1'b1 && dm_q.size() > 0) begin
            de = dm_q.pop_front();
            if (de.chk) begin
                checks++;
                if (dm_rdata_o !== de.data) begin
                    errors++;
                    $display("[TB] FAIL sb_dm_rdata: got %h, expected %h", dm_rdata_o, de.data);
                end
            end
        end
        if (if_stallreq_o === 1'b0 && prev_if === 1'b1 && if_q.size() > 0) begin
            de = if_q.pop_front();
            if (de.chk) begin
                checks++;
                if (if_data_o !== de.data) begin
                    errors++;
                    $display("[TB] FAIL sb_if_data: got %h, expected %h", if_data_o, de.data);
                end
            end
        end
        prev_req <= bus_req_o;
        prev_dm  <= dm_stallreq_o;
        prev_if  <= if_stallreq_o;
    end

    // Memory responder: waits for the next access, then acks after the given wait cycles.
    task automatic respond(input int waits, input logic [31:0] data);
        bit seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (bus_req_o === 1'b1) seen = 1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL respond_wait: bus_req_o got %b, expected 1 within 50 cycles", bus_req_o);
            return;
        end
        repeat (waits) @(negedge clk);
        bus_rdata_i = data;
        bus_ack_i   = 1'b1;
        @(posedge clk);
        #1;
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'h0;
    endtask

    // Counts stall and bus_req cycles of one port's request; returns at the negedge stall falls.
    task automatic measure(input bit use_if, output int stall_cyc, output int req_cyc,
                           output logic [31:0] data_at_fall, output logic [31:0] data_before);
        bit   fell = 0;
        logic s;
        stall_cyc    = 0;
        req_cyc      = 0;
        data_at_fall = 32'hX;
        data_before  = 32'hX;
        for (int i = 0; i < 60 && !fell; i++) begin
            @(negedge clk);
            s = use_if ? if_stallreq_o : dm_stallreq_o;
            if (s === 1'b1) begin
                stall_cyc++;
                if (bus_req_o === 1'b1) req_cyc++;
                data_before = use_if ? if_data_o : dm_rdata_o;
            end else if (stall_cyc > 0) begin
                data_at_fall = use_if ? if_data_o : dm_rdata_o;
                fell = 1;
            end
        end
        if (!fell) begin
            checks++;
            errors++;
            $display("[TB] FAIL measure_timeout: stall still %b after 60 cycles, expected 0", s);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (bus_req_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_bus_req: got %b, expected 0", bus_req_o); end
        checks++;
        if (bus_err_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_bus_err: got %b, expected 0", bus_err_o); end
        checks++;
        if ({bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o} !== 69'h0) begin
            errors++;
            $display("[TB] FAIL reset_bus_fields: got we %b sel %h addr %h wdata %h, expected all 0", bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o);
        end
        checks++;
        if ({if_data_o, dm_rdata_o} !== 64'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: got if %h dm %h, expected 0 0", if_data_o, dm_rdata_o);
        end
        checks++;
        if ({if_stallreq_o, dm_stallreq_o} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_stall: got %b, expected 00", {if_stallreq_o, dm_stallreq_o});
        end
    endtask

    task automatic test_single_load();
        int st, rq;
        logic [31:0] dfall, dbefore;
        @(posedge clk); #1;
        dm_ce_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h100; dm_sel_i = 4'hF; dm_wdata_i = 32'h0;
        bus_q.push_back('{1'b0, 32'h100, 4'hF, 32'h0, 1'b1});
        dm_q.push_back('{1'b1, 32'hDEADBEEF});
        fork
            respond(0, 32'hDEADBEEF);
            measure(1'b0, st, rq, dfall, dbefore);
        join
        checks++;
        if (st != 2) begin errors++; $display("[TB] FAIL load_stall_cycles: got %0d, expected 2", st); end
        checks++;
        if (rq != 1) begin errors++; $display("[TB] FAIL load_req_cycles: got %0d, expected 1", rq); end
        checks++;
        if (dfall !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL load_rdata: got %h, expected deadbeef", dfall); end
        @(posedge clk); #1;
        dm_ce_i = 1'b0;
    endtask

    task automatic test_dm_then_if();
        int dm_fall = -1;
        int if_fall = -1;
        @(posedge clk); #1;
        if_ce_i = 1'b1; if_addr_i = 32'h0;
        dm_ce_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h40; dm_sel_i = 4'b0011; dm_wdata_i = 32'h1234;
        bus_q.push_back('{1'b1, 32'h40, 4'b0011, 32'h1234, 1'b1});
        bus_q.push_back('{1'b0, 32'h0, 4'hF, 32'h0, 1'b0});
        dm_q.push_back('{1'b0, 32'h0});
        if_q.push_back('{1'b1, 32'hCAFEF00D});
        fork
            begin
                respond(0, 32'h0);
                respond(0, 32'hCAFEF00D);
            end
            begin
                for (int c = 0; c < 60 && if_fall < 0; c++) begin
                    @(negedge clk);
                    if (dm_fall < 0 && dm_stallreq_o === 1'b0) dm_fall = c;
                    if (if_fall < 0 && if_stallreq_o === 1'b0) if_fall = c;
                end
            end
        join
        checks++;
        if (dm_fall != 2) begin errors++; $display("[TB] FAIL prio_dm_fall: got cycle %0d, expected 2", dm_fall); end
        checks++;
        if (if_fall != 4) begin errors++; $display("[TB] FAIL prio_if_fall: got cycle %0d, expected 4", if_fall); end
        @(posedge clk); #1;
        if_ce_i = 1'b0; dm_ce_i = 1'b0; dm_we_i = 1'b0;
    endtask

    task automatic test_wait_states();
        int st, rq;
        logic [31:0] dfall, dbefore;
        @(posedge clk); #1;
        if_ce_i = 1'b1; if_addr_i = 32'h80;
        bus_q.push_back('{1'b0, 32'h80, 4'hF, 32'h0, 1'b0});
        if_q.push_back('{1'b1, 32'h0BADF00D});
        fork
            respond(3, 32'h0BADF00D);
            measure(1'b1, st, rq, dfall, dbefore);
        join
        checks++;
        if (st != 5) begin errors++; $display("[TB] FAIL wait_stall_cycles: got %0d, expected 5", st); end
        checks++;
        if (rq != 4) begin errors++; $display("[TB] FAIL wait_req_cycles: got %0d, expected 4", rq); end
        checks++;
        if (dbefore !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL wait_data_early: got %h, expected cafef00d", dbefore); end
        checks++;
        if (dfall !== 32'h0BADF00D) begin errors++; $display("[TB] FAIL wait_data_fall: got %h, expected 0badf00d", dfall); end
        @(posedge clk); #1;
        if_ce_i = 1'b0;
    endtask

    task automatic test_hold();
        int st, rq;
        logic [31:0] dfall, dbefore;
        bit fell = 0;
        @(posedge clk); #1;
        hold_i = 1'b1; if_ce_i = 1'b1; if_addr_i = 32'hC0;
        bus_q.push_back('{1'b0, 32'hC0, 4'hF, 32'h0, 1'b0});
        if_q.push_back('{1'b1, 32'hD1D1_0001});
        fork
            respond(0, 32'hD1D1_0001);
            measure(1'b1, st, rq, dfall, dbefore);
        join
        checks++;
        if (st != 2) begin errors++; $display("[TB] FAIL hold_first_stall: got %0d, expected 2", st); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if ({bus_req_o, if_stallreq_o} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL hold_idle: got req/stall %b, expected 00", {bus_req_o, if_stallreq_o});
            end
        end
        @(posedge clk); #1;
        hold_i = 1'b0; if_addr_i = 32'hC4;
        bus_q.push_back('{1'b0, 32'hC4, 4'hF, 32'h0, 1'b0});
        if_q.push_back('{1'b1, 32'hD2D2_0002});
        fork
            respond(1, 32'hD2D2_0002);
            begin
                @(negedge clk);
                checks++;
                if ({bus_req_o, if_stallreq_o} !== 2'b00) begin
                    errors++;
                    $display("[TB] FAIL hold_drop_cycle: got req/stall %b, expected 00", {bus_req_o, if_stallreq_o});
                end
                @(negedge clk);
                checks++;
                if ({bus_req_o, if_stallreq_o} !== 2'b01) begin
                    errors++;
                    $display("[TB] FAIL hold_restart_stall: got req/stall %b, expected 01", {bus_req_o, if_stallreq_o});
                end
                @(negedge clk);
                checks++;
                if (bus_req_o !== 1'b1) begin errors++; $display("[TB] FAIL hold_restart_req: got %b, expected 1", bus_req_o); end
                for (int c = 0; c < 40 && !fell; c++) begin
                    @(negedge clk);
                    if (if_stallreq_o === 1'b0) fell = 1;
                end
                checks++;
                if (!fell) begin errors++; $display("[TB] FAIL hold_second_fetch: stall got 1, expected 0 within 40 cycles"); end
            end
        join
        @(posedge clk); #1;
        if_ce_i = 1'b0;
    endtask

    task automatic test_idle_ack();
        @(posedge clk); #1;
        bus_rdata_i = 32'hFFFF_FFFF; bus_ack_i = 1'b1;
        @(posedge clk); #1;
        bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
        @(negedge clk);
        checks++;
        if (dm_rdata_o !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL idle_ack_dm: got %h, expected deadbeef", dm_rdata_o); end
        checks++;
        if (if_data_o !== 32'hD2D2_0002) begin errors++; $display("[TB] FAIL idle_ack_if: got %h, expected d2d20002", if_data_o); end
        checks++;
        if ({bus_req_o, bus_err_o} !== 2'b00) begin errors++; $display("[TB] FAIL idle_ack_bus: got req/err %b, expected 00", {bus_req_o, bus_err_o}); end
    endtask

    task automatic test_timeout();
        int st, rq;
        logic [31:0] dfall, dbefore;
        logic err_at_fall;
        @(posedge clk); #1;
        dm_ce_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h200; dm_sel_i = 4'hF;
        bus_q.push_back('{1'b0, 32'h200, 4'hF, 32'h0, 1'b0});
        dm_q.push_back('{1'b1, 32'h0});
        measure(1'b0, st, rq, dfall, dbefore);
        err_at_fall = bus_err_o;
        checks++;
        if (rq != 15) begin errors++; $display("[TB] FAIL timeout_req_cycles: got %0d, expected 15", rq); end
        checks++;
        if (st != 16) begin errors++; $display("[TB] FAIL timeout_stall_cycles: got %0d, expected 16", st); end
        checks++;
        if (dbefore !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL timeout_data_early: got %h, expected deadbeef", dbefore); end
        checks++;
        if (dfall !== 32'h0) begin errors++; $display("[TB] FAIL timeout_rdata: got %h, expected 0", dfall); end
        checks++;
        if (err_at_fall !== 1'b1) begin errors++; $display("[TB] FAIL timeout_err_set: got %b, expected 1", err_at_fall); end
        @(posedge clk); #1;
        dm_ce_i = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (bus_err_o !== 1'b1) begin errors++; $display("[TB] FAIL timeout_err_sticky: got %b, expected 1", bus_err_o); end
    endtask

    task automatic test_clr_mid_access();
        bit seen = 0;
        @(posedge clk); #1;
        dm_ce_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h300; dm_sel_i = 4'hF;
        bus_q.push_back('{1'b0, 32'h300, 4'hF, 32'h0, 1'b0});
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (bus_req_o === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin errors++; $display("[TB] FAIL clr_access_start: bus_req_o got %b, expected 1", bus_req_o); end
        @(posedge clk); #1;
        clr = 1'b1; dm_ce_i = 1'b0;
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_req_o !== 1'b0) begin errors++; $display("[TB] FAIL clr_bus_req: got %b, expected 0", bus_req_o); end
        checks++;
        if ({bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o} !== 69'h0) begin
            errors++;
            $display("[TB] FAIL clr_bus_fields: got we %b sel %h addr %h wdata %h, expected all 0", bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o);
        end
        checks++;
        if ({if_data_o, dm_rdata_o} !== 64'h0) begin errors++; $display("[TB] FAIL clr_data: got if %h dm %h, expected 0 0", if_data_o, dm_rdata_o); end
        checks++;
        if (bus_err_o !== 1'b0) begin errors++; $display("[TB] FAIL clr_bus_err: got %b, expected 0", bus_err_o); end
        @(posedge clk); #1;
        bus_rdata_i = 32'h5555_AAAA; bus_ack_i = 1'b1;
        @(posedge clk); #1;
        bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
        @(negedge clk);
        checks++;
        if ({bus_req_o, dm_rdata_o, if_data_o} !== 65'h0) begin
            errors++;
            $display("[TB] FAIL clr_late_ack: got req %b dm %h if %h, expected 0 0 0", bus_req_o, dm_rdata_o, if_data_o);
        end
    endtask

    initial begin
        clr = 1'b1; hold_i = 1'b0;
        if_ce_i = 1'b0; if_addr_i = 32'h0;
        dm_ce_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = 32'h0; dm_sel_i = 4'h0; dm_wdata_i = 32'h0;
        bus_rdata_i = 32'h0; bus_ack_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b0;

        test_reset();
        test_single_load();
        test_dm_then_if();
        test_wait_states();
        test_hold();
        test_idle_ack();
        test_timeout();
        test_clr_mid_access();

        repeat (2) @(negedge clk);
        checks++;
        if (bus_q.size() + dm_q.size() + if_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL sb_leftover: got %0d pending expectations, expected 0", bus_q.size() + dm_q.size() + if_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
